// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array controller.
// Optional feature macro used by systolic_ctrl: SYSTOLIC_AUTORESTART_EN.
package systolic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD_W = 3'd1;
  localparam state_t S_LOAD_X = 3'd2;
  localparam state_t S_FEED   = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int t_w(input int n);
    return $clog2(2 * n - 1);
  endfunction

  // A select value equal to the array size feeds zero into the lane.
  function automatic int sel_zero(input int n);
    return n;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_sel_gen.sv
// Skewed per-lane operand select generator for the systolic array.
// Lane i follows the feed counter delayed by i cycles, else feeds zero.
module skew_sel_gen
  import systolic_pkg::*;
#(
  parameter int N = 2,
  parameter int SEL_W = 2,
  localparam int T_W = t_w(N)
) (
  input  logic [T_W-1:0]     t,
  input  logic               feed_active,
  output logic [N*SEL_W-1:0] sel
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign sel[i*SEL_W +: SEL_W] =
      (feed_active && int'(t) >= i && int'(t) - i < N)
        ? SEL_W'(int'(t) - i)
        : SEL_W'(sel_zero(N));
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array.
// Define SYSTOLIC_AUTORESTART_EN to let start in DONE skip IDLE.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = 2,
  localparam int ADDR_W = $clog2(2 * N * N),
  localparam int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stat_weights,
  input  logic               load_weights,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  output logic               clear,
  output logic [N*SEL_W-1:0] row_sel,
  output logic [N*SEL_W-1:0] col_sel
);

  localparam int T_W = t_w(N);
  localparam logic [ADDR_W-1:0] LD_LAST = ADDR_W'(N * N - 1);
  localparam logic [ADDR_W-1:0] X_BASE = ADDR_W'(N * N);
  localparam logic [T_W-1:0] T_LAST = T_W'(2 * N - 2);
  localparam logic [T_W-1:0] DR_LAST = T_W'(N - 1);

  state_t state, state_n;
  logic [ADDR_W-1:0] ld_cnt, ld_n, addr_n;
  logic [T_W-1:0] t, t_n;
  logic weights_valid;
  logic need_w;
  logic rd_n;

  assign need_w = !stat_weights || load_weights || !weights_valid;

  always_comb begin
    state_n = state;
    ld_n = ld_cnt;
    t_n = t;
    case (state)
      S_IDLE: begin
        if (start) begin
          ld_n = '0;
          state_n = need_w ? S_LOAD_W : S_LOAD_X;
        end
      end
      S_LOAD_W: begin
        if (ld_cnt == LD_LAST) begin
          ld_n = '0;
          state_n = S_LOAD_X;
        end else begin
          ld_n = ld_cnt + ADDR_W'(1);
        end
      end
      S_LOAD_X: begin
        if (ld_cnt == LD_LAST) begin
          ld_n = '0;
          t_n = '0;
          state_n = S_FEED;
        end else begin
          ld_n = ld_cnt + ADDR_W'(1);
        end
      end
      S_FEED: begin
        t_n = t + T_W'(1);
        if (t == T_LAST) begin
          t_n = '0;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        t_n = t + T_W'(1);
        if (t == DR_LAST) begin
          t_n = '0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
`ifdef SYSTOLIC_AUTORESTART_EN
        if (start) begin
          ld_n = '0;
          state_n = need_w ? S_LOAD_W : S_LOAD_X;
        end else begin
          state_n = S_IDLE;
        end
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Address and strobe are registered off the next state so they
  // line up with the first load cycle.
  always_comb begin
    rd_n = (state_n == S_LOAD_W) || (state_n == S_LOAD_X);
    addr_n = '0;
    if (state_n == S_LOAD_W) addr_n = ld_n;
    if (state_n == S_LOAD_X) addr_n = X_BASE + ld_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ld_cnt <= '0;
      t <= '0;
      weights_valid <= 1'b0;
      mem_addr <= '0;
      mem_rd_en <= 1'b0;
    end else begin
      state <= state_n;
      ld_cnt <= ld_n;
      t <= t_n;
      mem_addr <= addr_n;
      mem_rd_en <= rd_n;
      if (state == S_LOAD_W && state_n == S_LOAD_X) weights_valid <= 1'b1;
    end
  end

  assign busy = (state == S_LOAD_W) || (state == S_LOAD_X) ||
                (state == S_FEED) || (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign clear = (state == S_FEED) && (t == '0);

  skew_sel_gen #(.N(N), .SEL_W(SEL_W)) u_row (
    .t(t),
    .feed_active(state == S_FEED),
    .sel(row_sel)
  );

  skew_sel_gen #(.N(N), .SEL_W(SEL_W)) u_col (
    .t(t),
    .feed_active(state == S_FEED),
    .sel(col_sel)
  );

endmodule
